// File: rtl/bus_memory.sv
`default_nettype none
// ============================================================================
//  Module   : bus_memory
//  Purpose  : 64-byte memory / I/O responder for the 6-bit-address, 8-bit-data
//             CPU bus. Holds program and data RAM, one synchronized input
//             port, one output port register, and a boot loader that streams
//             bytes into RAM after reset while holding the CPU in reset.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             addr, rw, wdata     - CPU bus request (rw: 1 = read, 0 = write)
//             rdata               - registered read data
//             in_port             - asynchronous external input byte
//             out_port,out_strobe - output port register and write pulse
//             load_valid/data/last, load_ready - loader byte stream
//             cpu_reset           - reset to the CPU, active-high
//  Revision : 1.0 - initial release
// ============================================================================
module bus_memory #(
  parameter bit         LOAD_EN  = 1'b1,
  parameter logic [5:0] IN_ADDR  = 6'd62,
  parameter logic [5:0] OUT_ADDR = 6'd63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic       out_strobe,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       cpu_reset
);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t     c_RESET_STATE = LOAD_EN ? S_LOAD : S_RUN;
  // Last loader address: the two top locations are shadowed by I/O.
  localparam logic [5:0] c_LAST_PTR    = 6'd61;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_accept;
  logic       w_load_ready;
  logic [5:0] r_ptr;
  logic       r_cpu_reset;

  logic [7:0] r_mem [0:63];

  logic [7:0] r_in_meta;
  logic [7:0] r_in_sync;
  logic [7:0] r_rdata;
  logic [7:0] r_out_port;
  logic       r_out_strobe;
  logic       r_rw_q;

  logic       w_run;
  logic       w_bus_wr;
  logic       w_hit_in;
  logic       w_hit_out;
  logic [7:0] w_rd_mux;

  // --------------------------------------------------------------------------
  // Loader state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_load_ready = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_load_ready = 1'b1;
        w_accept     = load_valid;
        if (w_accept && (load_last || (r_ptr == c_LAST_PTR))) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = c_RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= 6'd0;
      r_cpu_reset <= 1'b1;
    end else begin
      if (w_accept) begin
        r_ptr <= r_ptr + 6'd1;
      end
      // One edge of lag behind the state: CPU leaves reset the edge after RUN.
      r_cpu_reset <= (r_state == S_LOAD);
    end
  end

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_run     = (r_state == S_RUN);
  assign w_bus_wr  = w_run && !rw;
  assign w_hit_in  = (addr == IN_ADDR);
  assign w_hit_out = (addr == OUT_ADDR);

  always_comb begin
    w_rd_mux = r_mem[addr];
    if (w_hit_in) begin
      w_rd_mux = r_in_sync;
    end else if (w_hit_out) begin
      w_rd_mux = r_out_port;
    end
  end

  // RAM: single write port shared by loader and CPU (never both active,
  // since the loader only writes in LOAD and the bus only in RUN).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_ptr] <= load_data;
    end else if (w_bus_wr && !w_hit_in && !w_hit_out) begin
      r_mem[addr] <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Registered bus outputs and I/O
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_meta    <= 8'd0;
      r_in_sync    <= 8'd0;
      r_rdata      <= 8'd0;
      r_out_port   <= 8'd0;
      r_out_strobe <= 1'b0;
      r_rw_q       <= 1'b1;
    end else begin
      r_in_meta <= in_port;
      r_in_sync <= r_in_meta;
      // rw_q stays at "read" in LOAD so the first RUN write still strobes.
      r_rw_q    <= w_run ? rw : 1'b1;
      // Strobe only on the first cycle of a multi-cycle store.
      r_out_strobe <= w_bus_wr && w_hit_out && r_rw_q;
      if (w_run) begin
        r_rdata <= w_rd_mux;
      end
      if (w_bus_wr && w_hit_out) begin
        r_out_port <= wdata;
      end
    end
  end

  assign rdata      = r_rdata;
  assign out_port   = r_out_port;
  assign out_strobe = r_out_strobe;
  assign load_ready = w_load_ready;
  assign cpu_reset  = r_cpu_reset;

endmodule
`default_nettype wire

// File: doc/bus_memory.md
# bus_memory

Responder side of the 6-bit-address / 8-bit-data CPU bus: the 64-byte memory and I/O target that the CPU core drives via `addr`, `rw` and its write data. It holds program and data RAM, one input port, one output port, and a byte-stream loader that fills RAM after reset while holding the CPU in reset. It sits beside the CPU in the system top and is the only bus target.

## Interface

**Parameters**

- `LOAD_EN`, default 1: 1 enables the boot loader; 0 skips loading, so `cpu_reset` follows `reset` only.
- `IN_ADDR`, default 6'd62: address of the read-only input port.
- `OUT_ADDR`, default 6'd63: address of the output port register.

**Ports**

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `addr` in 6: bus address from the CPU.
- `rw` in 1: 1 = read, 0 = write.
- `wdata` in 8: write data from the CPU.
- `rdata` out 8: read data to the CPU, registered.
- `in_port` in 8: asynchronous external input.
- `out_port` out 8: output port register.
- `out_strobe` out 1: one-cycle pulse when `out_port` is written.
- `load_valid` in 1: loader byte valid.
- `load_data` in 8: loader byte.
- `load_last` in 1: marks the final loader byte.
- `load_ready` out 1: loader can accept a byte.
- `cpu_reset` out 1: reset to the CPU, active-high.

## Operation

**Storage**
- 64×8 RAM.
- RAM is not cleared by reset.
- Locations `IN_ADDR` and `OUT_ADDR` are shadowed by I/O and are never read from RAM.

**Loader state machine**
- States are LOAD and RUN.
- Reset enters LOAD when `LOAD_EN`=1, otherwise RUN.
- In LOAD:
  - `load_ready`=1 and `cpu_reset`=1.
  - A beat is accepted when `load_valid & load_ready`. It writes RAM[`ptr`] with `load_data`, then `ptr` increments. `ptr` resets to 0.
  - LOAD goes to RUN on an accepted beat with `load_last`=1, or on the accepted beat at `ptr`=61 (62 bytes fill addresses 0..61).
- RUN is terminal until reset. In RUN, `load_ready`=0 and further beats are ignored.
- `cpu_reset` is registered: it deasserts on the first edge after RUN is entered.

**Bus handling, RUN only**
- Bus inputs are ignored in LOAD.
- Every cycle, `rdata` is loaded with:
  - `in_sync` if `addr`==`IN_ADDR`;
  - `out_port` if `addr`==`OUT_ADDR`;
  - RAM[`addr`] otherwise.
- Read-first: a read of the address being written returns the old contents.
- Write with `rw`=0:
  - Sampled on every edge while `rw`=0, writing RAM[`addr`] with `wdata`. A store holding `rw` low for two cycles writes twice, which is idempotent.
  - Writes to `IN_ADDR` are dropped.
  - Writes to `OUT_ADDR` update `out_port`, not RAM.
- `out_strobe`:
  - Asserts for exactly one cycle, registered alongside the `out_port` update.
  - Only on the first cycle of a write to `OUT_ADDR`, detected as `rw`=0 with registered `rw_q`=1.
  - Consecutive write cycles with no intervening read cycle produce one strobe.
- `in_port` passes through a 2-flop synchronizer; its output is `in_sync`.

**Reset values**
- `rdata`=0, `out_port`=0, `out_strobe`=0.
- `load_ready`=`LOAD_EN`, `cpu_reset`=1, `ptr`=0, `rw_q`=1, synchronizer flops=0.
- A reset mid-load restarts at `ptr`=0. Bytes already loaded remain in RAM and are overwritten by the new load.

## Timing

- Read latency is 1 cycle: address stable before edge N gives `rdata` valid after edge N. The CPU holds `addr` for 2 edges before sampling, which gives one cycle of margin.
- A RAM write takes effect at the edge where `rw`=0 is sampled and is visible to a read whose address is sampled at the next edge.
- `in_port` to `rdata`: 3 edges minimum (2 synchronizer edges + 1 `rdata` register edge).
- Loader throughput: 1 byte per cycle while `load_valid` is held.
- `cpu_reset` falls 1 cycle after the final accepted beat.

## Test plan

- **Short load.** Load 0x12, 0x34, 0xC0 with `load_last` on the third byte. Required:
  - RAM[0..2] = 12/34/C0.
  - `load_ready` low on the cycle after the third beat.
  - `cpu_reset` low one cycle later.
  - A subsequent read of `addr` 1 returns 0x34.
- **Full load.** Hold `load_valid` for 70 cycles with no `load_last`. Required:
  - Exactly 62 beats are accepted.
  - RAM[61] holds the 62nd byte.
  - `load_ready`=0 thereafter.
- **Store/readback.** In RUN, drive `addr`=20, `wdata`=0xA5, `rw`=0 for 2 cycles, then `rw`=1. Required: `rdata`=0xA5 one cycle after the read address is presented. Reading during the first write cycle returns the old value.
- **Output port.** Write 0x5A to `addr` 63 with `rw` low for 2 cycles. Required:
  - `out_port`=0x5A.
  - `out_strobe` high for exactly 1 cycle.
  - RAM[63] unchanged.
  - A read of 63 returns 0x5A.
- **Input port and dropped write.** Set `in_port`=0x3C and hold `addr`=62. Required: `rdata`=0x3C within 3 cycles. A write of 0xFF to 62 leaves reads at 0x3C.
- **Reset mid-load.** Accept 5 bytes, assert `reset` for 1 cycle, then load 2 bytes with `load_last`. Required:
  - The bytes land at addresses 0..1.
  - `cpu_reset` stays high throughout, then falls after the second beat.
  - `out_port`=0.
